// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - CSR addresses, op encoding, mstatus fields and FSM states
// shared by the CSR access sequencer.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MSTATUS_MPP_LSB  = 11;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } csr_op_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_C_RD,
    S_C_WR,
    S_C_RSP,
    S_T_EPC,
    S_T_CAUSE,
    S_T_RST,
    S_T_WST,
    S_T_RVEC,
    S_T_REDIR
  } state_e;

  // Trap entry: stash MIE into MPIE, disable interrupts, record the prior privilege.
  function automatic logic [31:0] mstatus_on_trap(input logic [31:0] ms, input logic [1:0] mpp);
    logic [31:0] r;
    r = ms;
    r[MSTATUS_MPIE_BIT] = ms[MSTATUS_MIE_BIT];
    r[MSTATUS_MIE_BIT] = 1'b0;
    r[MSTATUS_MPP_LSB+1:MSTATUS_MPP_LSB] = mpp;
    return r;
  endfunction

endpackage

// File: rtl/csr_access_seq.sv
// rtl/csr_access_seq.sv - turns CSRRW/CSRRS/CSRRC requests into read-modify-write
// accesses on the CSR register file and runs the trap-entry sequence.
module csr_access_seq
  import csr_pkg::*;
#(
  parameter logic [1:0] MSTATUS_MPP = 2'b11
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_op_i,
  input  logic [11:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  input  logic        trap_i,
  input  logic [31:0] trap_cause_i,
  input  logic [31:0] trap_pc_i,
  output logic        trap_ack_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic [31:0] csr_addr_o,
  output logic        csr_we_o,
  output logic        csr_re_o,
  output logic [31:0] csr_wdata_o,
  output logic        csr_except_o,
  input  logic [31:0] csr_rdata_i
);

  state_e      r_state;
  state_e      w_next;
  csr_op_e     r_op;
  logic [11:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_cause;
  logic [31:0] r_pc;
  logic [31:0] r_old_q;
  logic [31:0] r_redir_pc;
  logic        r_trap_pend;

  logic        w_trap_take;
  logic        w_accept;
  logic        w_rmw_we;
  logic        w_vectored;
  logic [31:0] w_rmw_data;
  logic [31:0] w_base;
  logic [31:0] w_vec_pc;
  logic        w_unused;

  assign w_unused    = &{1'b0, trap_pc_i[1:0]};
  assign w_trap_take = trap_i & ~r_trap_pend & ~rst_i;
  assign trap_ack_o  = w_trap_take;
  assign req_ready_o = (r_state == S_IDLE) & ~trap_i & ~r_trap_pend & ~rst_i;
  assign w_accept    = req_valid_i & req_ready_o;

  always_comb begin
    case (r_op)
      OP_RS:   w_rmw_data = csr_rdata_i | r_wdata;
      OP_RC:   w_rmw_data = csr_rdata_i & ~r_wdata;
      default: w_rmw_data = r_wdata;
    endcase
  end

  // Set/clear with a zero mask must leave the CSR untouched, so suppress the write.
  assign w_rmw_we   = ~(((r_op == OP_RS) | (r_op == OP_RC)) & (r_wdata == 32'd0));
  assign w_base     = {csr_rdata_i[31:2], 2'b00};
  assign w_vectored = (csr_rdata_i[1:0] == 2'b01) & r_cause[31];
  assign w_vec_pc   = w_vectored ? (w_base + {r_cause[29:0], 2'b00}) : w_base;

  assign rsp_rdata_o   = r_old_q;
  assign redirect_pc_o = (r_state == S_T_REDIR) ? w_vec_pc : r_redir_pc;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_op        <= OP_RW;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cause     <= '0;
      r_pc        <= '0;
      r_old_q     <= '0;
      r_redir_pc  <= '0;
      r_trap_pend <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_trap_take) begin
        r_trap_pend <= 1'b1;
        r_cause     <= trap_cause_i;
        r_pc        <= {trap_pc_i[31:2], 2'b00};
      end else if (r_state == S_T_REDIR) begin
        r_trap_pend <= 1'b0;
      end
      if (w_accept) begin
        r_op    <= csr_op_e'(req_op_i);
        r_addr  <= req_addr_i;
        r_wdata <= req_wdata_i;
      end
      if (r_state == S_C_WR) r_old_q <= csr_rdata_i;
      if (r_state == S_T_REDIR) r_redir_pc <= w_vec_pc;
    end
  end

  always_comb begin
    w_next           = r_state;
    csr_addr_o       = '0;
    csr_we_o         = 1'b0;
    csr_re_o         = 1'b0;
    csr_except_o     = 1'b0;
    csr_wdata_o      = '0;
    rsp_valid_o      = 1'b0;
    redirect_valid_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (trap_i | r_trap_pend) w_next = S_T_EPC;
        else if (req_valid_i)     w_next = S_C_RD;
      end
      S_C_RD: begin
        csr_re_o   = 1'b1;
        csr_addr_o = {20'd0, r_addr};
        w_next     = S_C_WR;
      end
      S_C_WR: begin
        csr_addr_o  = {20'd0, r_addr};
        csr_we_o    = w_rmw_we;
        csr_wdata_o = w_rmw_we ? w_rmw_data : 32'd0;
        w_next      = S_C_RSP;
      end
      S_C_RSP: begin
        rsp_valid_o = 1'b1;
        w_next      = (r_trap_pend | trap_i) ? S_T_EPC : S_IDLE;
      end
      S_T_EPC: begin
        csr_we_o    = 1'b1;
        csr_addr_o  = {20'd0, CSR_MEPC};
        csr_wdata_o = r_pc;
        w_next      = S_T_CAUSE;
      end
      S_T_CAUSE: begin
        csr_we_o    = 1'b1;
        csr_addr_o  = {20'd0, CSR_MCAUSE};
        csr_wdata_o = r_cause;
        w_next      = S_T_RST;
      end
      S_T_RST: begin
        csr_re_o   = 1'b1;
        csr_addr_o = {20'd0, CSR_MSTATUS};
        w_next     = S_T_WST;
      end
      S_T_WST: begin
        csr_we_o    = 1'b1;
        csr_addr_o  = {20'd0, CSR_MSTATUS};
        csr_wdata_o = mstatus_on_trap(csr_rdata_i, MSTATUS_MPP);
        w_next      = S_T_RVEC;
      end
      S_T_RVEC: begin
        csr_except_o = 1'b1;
        csr_addr_o   = {20'd0, CSR_MTVEC};
        w_next       = S_T_REDIR;
      end
      S_T_REDIR: begin
        redirect_valid_o = 1'b1;
        w_next           = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_csr_access_seq.sv
// tb/tb_csr_access_seq.sv - scoreboard bench for csr_access_seq with a CSR
// register-file model and a queue-based reference of expected accesses.
module tb_csr_access_seq;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    int          c;
  } ev_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [1:0]  req_op_i = 2'b00;
  logic [11:0] req_addr_i = 12'h000;
  logic [31:0] req_wdata_i = 32'd0;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        trap_i = 1'b0;
  logic [31:0] trap_cause_i = 32'd0;
  logic [31:0] trap_pc_i = 32'd0;
  logic        trap_ack_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic [31:0] csr_addr_o;
  logic        csr_we_o;
  logic        csr_re_o;
  logic [31:0] csr_wdata_o;
  logic        csr_except_o;
  logic [31:0] csr_rdata_i = 32'd0;

  csr_access_seq dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .trap_i(trap_i), .trap_cause_i(trap_cause_i), .trap_pc_i(trap_pc_i),
    .trap_ack_o(trap_ack_o), .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .csr_addr_o(csr_addr_o), .csr_we_o(csr_we_o), .csr_re_o(csr_re_o),
    .csr_wdata_o(csr_wdata_o), .csr_except_o(csr_except_o), .csr_rdata_i(csr_rdata_i)
  );

  ev_t exp_wr[$];
  ev_t exp_rd[$];
  ev_t exp_rsp[$];
  ev_t exp_redir[$];
  logic [31:0] mem [4096];
  logic [31:0] ref_csr [4096];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int onehot_bad = 0;
  logic        mem_clr = 1'b1;
  logic        bd_we = 1'b0;
  logic [11:0] bd_addr = 12'h000;
  logic [31:0] bd_data = 32'd0;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  always @(posedge clk_i) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 32'd0;
    end else begin
      if (csr_re_o || csr_except_o) csr_rdata_i <= mem[csr_addr_o[11:0]];
      if (csr_we_o) mem[csr_addr_o[11:0]] <= csr_wdata_o;
      if (bd_we) mem[bd_addr] <= bd_data;
    end
  end

  task automatic ev_chk(input string name, input bit have, input ev_t e,
                        input logic [31:0] a, input logic [31:0] d);
    checks++;
    if (!have) begin
      errors++;
      $display("FAIL %s unexpected: actual a=%h d=%h cyc=%0d, required none", name, a, d, cyc);
    end else if (e.a !== a || e.d !== d || e.c != cyc) begin
      errors++;
      $display("FAIL %s actual a=%h d=%h cyc=%0d required a=%h d=%h cyc=%0d",
               name, a, d, cyc, e.a, e.d, e.c);
    end
  endtask

  always @(negedge clk_i) begin : monitor
    ev_t e;
    bit  h;
    if (!rst_i) begin
      if (int'(csr_we_o) + int'(csr_re_o) + int'(csr_except_o) > 1) onehot_bad++;
      if (csr_we_o) begin
        h = exp_wr.size() > 0;
        if (h) e = exp_wr.pop_front(); else e = '{32'd0, 32'd0, 0};
        ev_chk("csr_write", h, e, csr_addr_o, csr_wdata_o);
      end
      if (csr_re_o || csr_except_o) begin
        h = exp_rd.size() > 0;
        if (h) e = exp_rd.pop_front(); else e = '{32'd0, 32'd0, 0};
        ev_chk("csr_read", h, e, csr_addr_o, {31'd0, csr_except_o});
      end
      if (rsp_valid_o) begin
        h = exp_rsp.size() > 0;
        if (h) e = exp_rsp.pop_front(); else e = '{32'd0, 32'd0, 0};
        ev_chk("rsp", h, e, 32'd0, rsp_rdata_o);
      end
      if (redirect_valid_o) begin
        h = exp_redir.size() > 0;
        if (h) e = exp_redir.pop_front(); else e = '{32'd0, 32'd0, 0};
        ev_chk("redirect", h, e, 32'd0, redirect_pc_o);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, expv);
    end
  endtask

  task automatic check_outs_zero(input string tag);
    chk({tag, "_ctrl"}, {23'd0, req_ready_o, rsp_valid_o, trap_ack_o, redirect_valid_o,
                         csr_we_o, csr_re_o, csr_except_o, 2'b00}, 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata_o, 32'd0);
    chk({tag, "_redirect_pc"}, redirect_pc_o, 32'd0);
    chk({tag, "_csr_addr"}, csr_addr_o, 32'd0);
    chk({tag, "_csr_wdata"}, csr_wdata_o, 32'd0);
  endtask

  task automatic set_csr(input logic [11:0] a, input logic [31:0] v);
    bd_we = 1'b1; bd_addr = a; bd_data = v;
    ref_csr[a] = v;
    @(posedge clk_i); #1;
    bd_we = 1'b0;
  endtask

  task automatic push_req(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd, input int c0);
    logic [31:0] old;
    logic [31:0] nv;
    old = ref_csr[a];
    case (op)
      2'b10:   nv = old | wd;
      2'b11:   nv = old & ~wd;
      default: nv = wd;
    endcase
    exp_rd.push_back('{{20'd0, a}, 32'd0, c0 + 1});
    if (!((op == 2'b10 || op == 2'b11) && wd == 32'd0)) begin
      exp_wr.push_back('{{20'd0, a}, nv, c0 + 2});
      ref_csr[a] = nv;
    end
    exp_rsp.push_back('{32'd0, old, c0 + 3});
  endtask

  task automatic push_trap(input logic [31:0] cause, input logic [31:0] pc, input int s, input bit full);
    logic [31:0] ms;
    logic [31:0] nm;
    logic [31:0] tv;
    logic [31:0] tgt;
    exp_wr.push_back('{32'h341, pc & 32'hFFFF_FFFC, s});
    ref_csr[12'h341] = pc & 32'hFFFF_FFFC;
    exp_wr.push_back('{32'h342, cause, s + 1});
    ref_csr[12'h342] = cause;
    if (full) begin
      exp_rd.push_back('{32'h300, 32'd0, s + 2});
      ms = ref_csr[12'h300];
      nm = (ms & ~32'h0000_1888) | ((ms & 32'h8) << 4) | 32'h0000_1800;
      exp_wr.push_back('{32'h300, nm, s + 3});
      ref_csr[12'h300] = nm;
      exp_rd.push_back('{32'h305, 32'd1, s + 4});
      tv = ref_csr[12'h305];
      tgt = tv & 32'hFFFF_FFFC;
      if (tv[1:0] == 2'b01 && cause[31]) tgt = tgt + (cause & 32'h3FFF_FFFF) * 4;
      exp_redir.push_back('{32'd0, tgt, s + 5});
    end
  endtask

  task automatic wait_accept(output int c, output bit ok);
    ok = 1'b0;
    c = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_i);
      if (req_ready_o) begin ok = 1'b1; c = cyc; break; end
    end
    @(posedge clk_i); #1;
    checks++;
    if (!ok) begin errors++; $display("FAIL req_accept timeout actual=none required=accept"); end
  endtask

  task automatic do_req(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd);
    int c;
    bit ok;
    req_valid_i = 1'b1; req_op_i = op; req_addr_i = a; req_wdata_i = wd;
    wait_accept(c, ok);
    req_valid_i = 1'b0;
    if (ok) push_req(op, a, wd, c);
  endtask

  task automatic do_trap(input logic [31:0] cause, input logic [31:0] pc, input bit full);
    int c;
    bit got;
    trap_i = 1'b1; trap_cause_i = cause; trap_pc_i = pc;
    got = 1'b0;
    c = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_i);
      if (trap_ack_o) begin got = 1'b1; c = cyc; break; end
    end
    @(posedge clk_i); #1;
    trap_i = 1'b0;
    checks++;
    if (!got) begin errors++; $display("FAIL trap_ack timeout actual=none required=ack"); end
    else push_trap(cause, pc, c + 1, full);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_wr.size() + exp_rd.size() + exp_rsp.size() + exp_redir.size()) > 0 && n < 80) begin
      @(negedge clk_i);
      n++;
    end
    checks++;
    if ((exp_wr.size() + exp_rd.size() + exp_rsp.size() + exp_redir.size()) > 0) begin
      errors++;
      $display("FAIL drain actual pending wr=%0d rd=%0d rsp=%0d redir=%0d required 0",
               exp_wr.size(), exp_rd.size(), exp_rsp.size(), exp_redir.size());
      exp_wr.delete(); exp_rd.delete(); exp_rsp.delete(); exp_redir.delete();
    end
    @(posedge clk_i); #1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int c1;
    bit ok;
    logic [11:0] addr_tab [6];
    addr_tab = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h7C0};
    for (int i = 0; i < 4096; i++) ref_csr[i] = 32'd0;

    repeat (3) @(posedge clk_i);
    #1 mem_clr = 1'b0;
    @(negedge clk_i);
    check_outs_zero("reset");
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    set_csr(12'h340, 32'h1234_5678);
    do_req(2'b01, 12'h340, 32'hDEAD_BEEF);
    drain();
    chk("rw_rsp_hold", rsp_rdata_o, 32'h1234_5678);

    set_csr(12'h300, 32'h0000_1808);
    do_req(2'b10, 12'h300, 32'd0);
    drain();
    set_csr(12'h300, 32'h0000_0088);
    do_req(2'b11, 12'h300, 32'h0000_0008);
    drain();
    chk("rc_mstatus", mem[12'h300], 32'h0000_0080);

    set_csr(12'h300, 32'h0000_0008);
    set_csr(12'h305, 32'h0000_0100);
    do_trap(32'h0000_0002, 32'h0000_1003, 1'b1);
    drain();
    chk("trap_mstatus", mem[12'h300], 32'h0000_1880);
    chk("trap_redirect_hold", redirect_pc_o, 32'h0000_0100);

    set_csr(12'h305, 32'h0000_0201);
    do_trap(32'h8000_0007, 32'h0000_4000, 1'b1);
    drain();
    chk("vectored_pc", redirect_pc_o, 32'h0000_021C);
    do_trap(32'h0000_0002, 32'h0000_4004, 1'b1);
    drain();
    chk("vector_exception_pc", redirect_pc_o, 32'h0000_0200);

    set_csr(12'h340, 32'hA5A5_0000);
    req_valid_i = 1'b1; req_op_i = 2'b10; req_addr_i = 12'h340; req_wdata_i = 32'h0000_00FF;
    wait_accept(c0, ok);
    if (ok) push_req(2'b10, 12'h340, 32'h0000_00FF, c0);
    req_op_i = 2'b01; req_wdata_i = 32'h0000_1234;
    @(posedge clk_i); #1;
    trap_i = 1'b1; trap_cause_i = 32'h0000_000B; trap_pc_i = 32'h0000_2002;
    @(negedge clk_i);
    chk("ack_in_cwr", {31'd0, trap_ack_o}, 32'd1);
    @(posedge clk_i); #1;
    trap_i = 1'b0;
    push_trap(32'h0000_000B, 32'h0000_2002, c0 + 4, 1'b1);
    wait_accept(c1, ok);
    req_valid_i = 1'b0;
    if (ok) push_req(2'b01, 12'h340, 32'h0000_1234, c1);
    chk("held_req_accept_cycle", c1, c0 + 10);
    drain();

    do_trap(32'h0000_0005, 32'h0000_3000, 1'b0);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(negedge clk_i);
    check_outs_zero("mid_reset");
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    drain();
    chk("partial_mepc", mem[12'h341], 32'h0000_3000);
    do_trap(32'h8000_0003, 32'h0000_4444, 1'b1);
    drain();

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        do_trap($urandom(), $urandom(), 1'b1);
      end else begin
        do_req(2'($urandom_range(0, 3)), addr_tab[$urandom_range(0, 5)],
               ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom());
      end
      drain();
    end

    chk("strobe_onehot_violations", onehot_bad, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_access_seq.md
# csr_access_seq

Initiator-side sequencer for the machine-mode CSR register file. Converts pipeline CSR instructions (CSRRW/CSRRS/CSRRC) into read-modify-write accesses on the register file's address/read/write/except port. Runs the trap-entry sequence: save mepc, save mcause, update mstatus, fetch mtvec, redirect the PC. Sits between the execute stage and the CSR register file.

## Interface
- `MSTATUS_MPP`, default 2'b11, privilege written to mstatus.MPP on trap entry.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `req_valid_i`  in  1  CSR instruction request.
- `req_ready_o`  out  1  request accepted when valid&ready.
- `req_op_i`  in  2  01=RW, 10=RS (set), 11=RC (clear); 00 is treated as RW.
- `req_addr_i`  in  12  CSR address.
- `req_wdata_i`  in  32  rs1/immediate operand.
- `rsp_valid_o`  out  1  one-cycle pulse; old CSR value on `rsp_rdata_o`.
- `rsp_rdata_o`  out  32  old CSR value, held until the next response.
- `trap_i`  in  1  trap request, level; sampled when accepted.
- `trap_cause_i`  in  32  mcause value; bit 31 = interrupt.
- `trap_pc_i`  in  32  faulting PC.
- `trap_ack_o`  out  1  one-cycle pulse when the trap is captured.
- `redirect_valid_o`  out  1  one-cycle pulse.
- `redirect_pc_o`  out  32  trap handler address.
- `csr_addr_o`  out  32  zero-extended 12-bit CSR address.
- `csr_we_o`  out  1  write strobe.
- `csr_re_o`  out  1  read strobe.
- `csr_wdata_o`  out  32  write data.
- `csr_except_o`  out  1  exception-mode read enable.
- `csr_rdata_i`  in  32  register-file read data, registered. Valid the cycle after `csr_re_o` or `csr_except_o`, and held afterwards.

## Operation
- States:
  - Request path: IDLE, C_RD, C_WR, C_RSP.
  - Trap path: T_EPC, T_CAUSE, T_RST, T_WST, T_RVEC, T_REDIR.
- IDLE:
  - If `trap_i`: capture cause/pc, pulse `trap_ack_o`, go to T_EPC.
  - Else if `req_valid_i`: capture op/addr/wdata, go to C_RD.
  - Trap has priority over a simultaneous request; `req_ready_o` = IDLE & !trap_i & !trap_pend.
- C_RD: `csr_re_o`=1, addr=req addr.
- C_WR:
  - Capture `csr_rdata_i` into `old_q`.
  - Drive `csr_we_o`=1 with new value: RW = wdata; RS = old | wdata; RC = old & ~wdata.
  - RS/RC with wdata==0: no write (`csr_we_o`=0).
- C_RSP: `rsp_valid_o`=1, `rsp_rdata_o`=`old_q`. Go to T_EPC if `trap_pend`, else IDLE.
- `trap_i` asserted outside IDLE sets `trap_pend` and latches cause/pc (first trap wins); it is acked at latch time.
- Trap path:
  - T_EPC: we, addr 0x341, data = {pc[31:2], 2'b00}.
  - T_CAUSE: we, addr 0x342, data = cause.
  - T_RST: re, addr 0x300.
  - T_WST: we, addr 0x300; data = rdata with MPIE(7) = MIE(3), MIE(3) = 0, MPP(12:11) = `MSTATUS_MPP`.
  - T_RVEC: `csr_except_o`=1, addr 0x305, `csr_re_o`=0.
  - T_REDIR:
    - base = {rdata[31:2], 2'b00}.
    - If rdata[1:0]==01 and cause[31]: pc = base + (cause[29:0] << 2), modulo 2^32.
    - Else pc = base.
    - Pulse `redirect_valid_o`, clear `trap_pend`, go to IDLE.
- `csr_except_o` is low in every state except T_RVEC, so all trap writes land in the register file.
- At most one of we / re / except is high in any cycle.

## Timing
- Reset: all outputs 0, state IDLE, `trap_pend`=0, `old_q`=0.
- Reset mid-sequence aborts immediately; partial CSR writes are not undone.
- CSR instruction: accept at cycle 0, re at 1, we at 2, `rsp_valid_o` at 3. Next accept earliest at cycle 4.
- Trap from IDLE: ack at cycle 0, mepc write at 1, mcause at 2, mstatus read at 3, mstatus write at 4, mtvec read at 5, redirect at 6.
- `redirect_pc_o` and `rsp_rdata_o` are registered outputs; they change only on their valid pulse and hold otherwise.
- A request held valid during a trap is accepted in the first IDLE cycle after redirect.

## Structure
- Shared package `csr_pkg`:
  - CSR address constants (0x300, 0x305, 0x341, 0x342, …).
  - op encoding.
  - mstatus bit positions.
  - state enum.
- No sub-module. One FSM plus capture registers; the RMW combiner is inline logic.

## Test plan
- RW to 0x340 with wdata 0xDEADBEEF, prior value 0x12345678 -> write 0xDEADBEEF at cycle 2, rsp 0x12345678 at cycle 3.
- RS with wdata 0 on 0x300 -> no `csr_we_o`, rsp = current mstatus. RC with wdata 0x8 on mstatus 0x88 -> write 0x80.
- Trap, cause 0x2, pc 0x1003, mstatus 0x8, mtvec 0x100 -> writes mepc 0x1000, mcause 0x2, mstatus 0x1880; redirect 0x100 at cycle 6.
- Vectored: mtvec 0x201, cause 0x80000007 -> redirect 0x21C. Same mtvec with cause 0x2 -> 0x200.
- `trap_i` during C_WR of a request -> request completes (rsp pulse), then trap sequence starts with the latched cause; req_ready stays low throughout.
- `rst_i` asserted during T_RST -> all outputs 0 next edge, IDLE. A fresh trap after release completes normally.
